sf2_ujtag_tap: RTL and testbench
================================

Name: sf2_ujtag_tap

Overview:
- Behavioural simulation model of the SmartFusion2 JTAG TAP responder: the device end of the JTAG link.
- It is the counterpart that presents the fabric-side user-JTAG signals consumed by UJTAG-style user logic.
- It decodes TMS/TDI into the IEEE 1149.1 16-state TAP controller, an instruction register, and BYPASS/IDCODE data registers.
- User instructions are forwarded to fabric logic as UIREG plus capture/shift/update strobes.
- Used in simulation netlists alongside the other SF2 cell models.

Parameters:
- IR_W, 8, instruction register width (min 2).
- IDCODE, 32'h0F8011CF, device ID value; bit 0 must be 1.
- USER_LO, 8'h10, lowest opcode routed to fabric.
- USER_HI, 8'h1F, highest opcode routed to fabric.

Ports:
- CLK  input  1  TCK; all state updates on the rising edge, TDO on the falling edge.
- ALn  input  1  TRSTB; asynchronous, active-low reset.
- TMS  input  1  test mode select.
- TDI  input  1  test data in.
- TDO  output  1  test data out.
- TDO_EN  output  1  TDO drive enable.
- UIREG  output  IR_W  current instruction, valid while it is a user opcode, else 0.
- URSTB  output  1  fabric reset, low while in Test-Logic-Reset.
- UDRCAP  output  1  high in Capture-DR with a user instruction.
- UDRSH  output  1  high in Shift-DR with a user instruction.
- UDRUPD  output  1  high in Update-DR with a user instruction.
- UTDI  output  1  equals TDI.
- UTDO  input  1  fabric DR serial out, selected in Shift-DR with a user instruction.

Behaviour:
- ALn low, asynchronous: state = Test-Logic-Reset (TLR); IR = IDCODE opcode 8'h01 (zero-extended to IR_W); bypass = 0; ID shift = IDCODE.
- Outputs during reset: TDO = 0, TDO_EN = 0, URSTB = 0, UIREG = 0, UDRCAP/UDRSH/UDRUPD = 0.
- FSM: standard 16 states, transitions on posedge CLK by TMS.
- TLR: TMS=0 -> Run-Test-Idle (RTI), else stay.
- RTI: 1 -> Select-DR.
- Select-DR: 0 -> Capture-DR, 1 -> Select-IR.
- Select-IR: 0 -> Capture-IR, 1 -> TLR.
- Capture-x: 0 -> Shift-x, 1 -> Exit1-x.
- Shift-x: 1 -> Exit1-x.
- Exit1-x: 0 -> Pause-x, 1 -> Update-x.
- Pause-x: 1 -> Exit2-x.
- Exit2-x: 0 -> Shift-x, 1 -> Update-x.
- Update-x: 0 -> RTI, 1 -> Select-DR.
- Five consecutive TMS=1 edges reach TLR from any state. Entering TLR loads IR = IDCODE opcode.
- IR path:
  - Capture-IR loads shift reg = {0..0, 2'b01}.
  - Shift-IR shifts LSB-first, TDI into MSB.
  - Update-IR copies shift reg to IR.
  - IR never changes mid-shift.
- DR selected by IR:
  - 8'h01 -> 32-bit ID reg, loaded with IDCODE in Capture-DR.
  - USER_LO..USER_HI -> fabric (UTDO).
  - All other opcodes, including all-ones -> 1-bit bypass, loaded 0 in Capture-DR.
- Shifts occur on the posedge while the state is Shift-DR/Shift-IR.
- TDO: updated on negedge CLK with the LSB of the selected register (UTDO for user opcodes).
- TDO_EN: 1 only while the state is Shift-IR or Shift-DR, else TDO_EN = 0 and TDO = 0.
- UDRCAP/UDRSH/UDRUPD: combinational decode of the registered state and IR; glitch-free; each asserted for exactly the cycles the state holds.
- URSTB: 0 iff the state is TLR.
- UTDI: wire from TDI.
- ALn asserted mid-shift: shift contents discarded, IR returns to IDCODE, no Update strobe generated.

Optional Feature:
- Macro: SF2_UJTAG_TAP_IDCODE_EN.
- Defined: IDCODE register present as described.
- Undefined: no ID register; opcode 8'h01 behaves as BYPASS; reset and TLR load IR = all-ones (BYPASS); first DR scan after reset returns a single 0 then TDI delayed by 1.

Test Plan:
- ALn low then high, TMS=1 for 5 edges from Shift-DR -> state TLR, URSTB=0, IR=8'h01, TDO_EN=0.
- From TLR: TMS 0,1,0,0, then 32 Shift-DR clocks -> TDO serial LSB-first = 32'h0F8011CF.
- IR scan of 8'hFF, Update-IR, DR scan of TDI pattern 1,0,1,1 -> TDO = 0,1,0,1 (one-bit delay).
- IR scan shifting in 8'h12 -> TDO during Shift-IR begins 1,0,0,0,0,0,0,0; after Update-IR UIREG=8'h12.
- With UIREG=8'h12, one DR scan -> UDRCAP high 1 cycle, UDRSH high for each Shift-DR cycle, UDRUPD high 1 cycle; TDO mirrors UTDO.
- ALn pulsed low during the 10th Shift-DR clock -> immediate TLR, TDO=0, no UDRUPD pulse, UIREG=0; with the macro undefined, the subsequent DR scan behaves as bypass.

Source files
------------

// File: rtl/sf2_ujtag_tap.sv
// sf2_ujtag_tap -- behavioural model of the SmartFusion2 JTAG TAP responder.
//
// Decodes TMS/TDI into the 16-state IEEE 1149.1 TAP controller with an
// instruction register and BYPASS / IDCODE data registers. User opcodes in
// USER_LO..USER_HI are handed to fabric logic as UIREG plus the
// capture/shift/update strobes, and their DR serial data comes from UTDO.
//
// Build option: define SF2_UJTAG_TAP_IDCODE_EN to include the 32-bit ID
// register (opcode 8'h01, selected after reset). Without it opcode 8'h01 is
// plain BYPASS and reset/Test-Logic-Reset load IR with all-ones.
//
// Ports:
//   CLK     TCK; state updates on rising edge, TDO on falling edge
//   ALn     TRSTB, asynchronous active-low reset
//   TMS     test mode select
//   TDI     test data in
//   TDO     test data out (0 when not shifting)
//   TDO_EN  TDO drive enable, high only in Shift-IR / Shift-DR
//   UIREG   current instruction while it is a user opcode, else 0
//   URSTB   fabric reset, low while in Test-Logic-Reset
//   UDRCAP  Capture-DR with a user instruction
//   UDRSH   Shift-DR with a user instruction
//   UDRUPD  Update-DR with a user instruction
//   UTDI    copy of TDI for fabric DR logic
//   UTDO    fabric DR serial out
module sf2_ujtag_tap #(
  parameter int          IR_W    = 8,
  parameter logic [31:0] IDCODE  = 32'h0F8011CF,
  parameter logic [7:0]  USER_LO = 8'h10,
  parameter logic [7:0]  USER_HI = 8'h1F
) (
  input  logic            CLK,
  input  logic            ALn,
  input  logic            TMS,
  input  logic            TDI,
  output logic            TDO,
  output logic            TDO_EN,
  output logic [IR_W-1:0] UIREG,
  output logic            URSTB,
  output logic            UDRCAP,
  output logic            UDRSH,
  output logic            UDRUPD,
  output logic            UTDI,
  input  logic            UTDO
);

  typedef enum logic [3:0] {
    S_TLR, S_RTI,
    S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PA_DR, S_EX2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PA_IR, S_EX2_IR, S_UPD_IR
  } tap_state_t;

  // Capture-IR pattern: the mandatory 2'b01 in the two LSBs.
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);
  localparam logic [IR_W-1:0] USER_LO_IR = IR_W'(USER_LO);
  localparam logic [IR_W-1:0] USER_HI_IR = IR_W'(USER_HI);

`ifdef SF2_UJTAG_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(8'h01);
  localparam logic [IR_W-1:0] IR_RESET  = OP_IDCODE;
`else
  localparam logic [IR_W-1:0] IR_RESET  = '1;
`endif

  tap_state_t      state_reg, state_next;
  logic [IR_W-1:0] ir_reg, ir_shift_reg;
  logic            bypass_reg;
  logic            tdo_reg, tdo_en_reg;
  logic            is_user, in_shift, dr_lsb;

  // ---------------- TAP controller ----------------
  always_ff @(posedge CLK or negedge ALn) begin
    if (!ALn) state_reg <= S_TLR;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_TLR:    state_next = TMS ? S_TLR    : S_RTI;
      S_RTI:    state_next = TMS ? S_SEL_DR : S_RTI;
      S_SEL_DR: state_next = TMS ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: state_next = TMS ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  state_next = TMS ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: state_next = TMS ? S_UPD_DR : S_PA_DR;
      S_PA_DR:  state_next = TMS ? S_EX2_DR : S_PA_DR;
      S_EX2_DR: state_next = TMS ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: state_next = TMS ? S_SEL_DR : S_RTI;
      S_SEL_IR: state_next = TMS ? S_TLR    : S_CAP_IR;
      S_CAP_IR: state_next = TMS ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  state_next = TMS ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: state_next = TMS ? S_UPD_IR : S_PA_IR;
      S_PA_IR:  state_next = TMS ? S_EX2_IR : S_PA_IR;
      S_EX2_IR: state_next = TMS ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: state_next = TMS ? S_SEL_DR : S_RTI;
      default:  state_next = S_TLR;
    endcase
  end

  // ---------------- Instruction register ----------------
  // IR is written only when entering TLR or on the edge leaving Update-IR,
  // so it stays stable for the whole of an IR shift.
  always_ff @(posedge CLK or negedge ALn) begin
    if (!ALn) begin
      ir_reg       <= IR_RESET;
      ir_shift_reg <= IR_CAPTURE;
    end else begin
      if (state_next == S_TLR)       ir_reg <= IR_RESET;
      else if (state_reg == S_UPD_IR) ir_reg <= ir_shift_reg;

      if (state_reg == S_CAP_IR)     ir_shift_reg <= IR_CAPTURE;
      else if (state_reg == S_SH_IR) ir_shift_reg <= {TDI, ir_shift_reg[IR_W-1:1]};
    end
  end

  assign is_user = (ir_reg >= USER_LO_IR) && (ir_reg <= USER_HI_IR);

  // ---------------- Data registers ----------------
  always_ff @(posedge CLK or negedge ALn) begin
    if (!ALn)                      bypass_reg <= 1'b0;
    else if (state_reg == S_CAP_DR) bypass_reg <= 1'b0;
    else if (state_reg == S_SH_DR)  bypass_reg <= TDI;
  end

`ifdef SF2_UJTAG_TAP_IDCODE_EN
  logic [31:0] id_shift_reg;

  always_ff @(posedge CLK or negedge ALn) begin
    if (!ALn)                      id_shift_reg <= IDCODE;
    else if (state_reg == S_CAP_DR) id_shift_reg <= IDCODE;
    else if (state_reg == S_SH_DR)  id_shift_reg <= {TDI, id_shift_reg[31:1]};
  end

  assign dr_lsb = is_user              ? UTDO :
                  (ir_reg == OP_IDCODE) ? id_shift_reg[0] : bypass_reg;
`else
  // IDCODE has no consumer when the ID register is left out.
  logic unused_idcode;
  assign unused_idcode = ^IDCODE;

  assign dr_lsb = is_user ? UTDO : bypass_reg;
`endif

  // ---------------- TDO (falling edge) ----------------
  always_ff @(negedge CLK or negedge ALn) begin
    if (!ALn) begin
      tdo_reg    <= 1'b0;
      tdo_en_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_SH_IR: begin tdo_reg <= ir_shift_reg[0]; tdo_en_reg <= 1'b1; end
        S_SH_DR: begin tdo_reg <= dr_lsb;          tdo_en_reg <= 1'b1; end
        default: begin tdo_reg <= 1'b0;            tdo_en_reg <= 1'b0; end
      endcase
    end
  end

  // Gating with the live state drops the enable on the same rising edge
  // that leaves a Shift state rather than half a cycle later.
  assign in_shift = (state_reg == S_SH_IR) || (state_reg == S_SH_DR);
  assign TDO_EN   = tdo_en_reg & in_shift;
  assign TDO      = tdo_reg & TDO_EN;

  // ---------------- Fabric-side outputs ----------------
  assign URSTB  = (state_reg != S_TLR);
  assign UIREG  = is_user ? ir_reg : '0;
  assign UDRCAP = is_user && (state_reg == S_CAP_DR);
  assign UDRSH  = is_user && (state_reg == S_SH_DR);
  assign UDRUPD = is_user && (state_reg == S_UPD_DR);
  assign UTDI   = TDI;

endmodule

// File: tb/tb_sf2_ujtag_tap.sv
// Directed bench for sf2_ujtag_tap: a table of per-clock TMS/TDI/UTDO
// vectors with hand-computed outputs, plus hand-written sequences for reset,
// the five-TMS=1 return to TLR, a full 32-bit DR scan and reset mid-shift.
module tb_sf2_ujtag_tap;

  localparam logic [31:0] ID_VAL = 32'h0F8011CF;

  logic       CLK = 1'b0;
  logic       ALn, TMS, TDI, UTDO;
  logic       TDO, TDO_EN, URSTB, UDRCAP, UDRSH, UDRUPD, UTDI;
  logic [7:0] UIREG;

  int n_cmp  = 0;
  int n_fail = 0;

  sf2_ujtag_tap #(
    .IR_W(8), .IDCODE(ID_VAL), .USER_LO(8'h10), .USER_HI(8'h1F)
  ) dut (
    .CLK(CLK), .ALn(ALn), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .UIREG(UIREG), .URSTB(URSTB), .UDRCAP(UDRCAP), .UDRSH(UDRSH),
    .UDRUPD(UDRUPD), .UTDI(UTDI), .UTDO(UTDO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       tms, tdi, utdo;
    logic       en, tdo, urstb;
    logic [7:0] uireg;
    logic       cap, sh, upd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic tms, tdi, utdo, en, tdo, urstb,
                     input logic [7:0] uireg, input logic cap, sh, upd);
    vec_t v;
    v.tms = tms; v.tdi = tdi; v.utdo = utdo; v.en = en; v.tdo = tdo;
    v.urstb = urstb; v.uireg = uireg; v.cap = cap; v.sh = sh; v.upd = upd;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One TCK cycle; outputs are sampled 1 ns after the falling edge.
  task automatic step(input logic tms, input logic tdi, input logic utdo);
    TMS = tms; TDI = tdi; UTDO = utdo;
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  // From RTI: 32-bit DR scan, TDO sampled before each shifting edge; ends in RTI.
  task automatic dr_scan32(input logic [31:0] din, output logic [31:0] dout);
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int k = 0; k < 32; k++) begin
      dout[k] = TDO;
      step(k == 31, din[k], 0);
    end
    step(1, 0, 0); step(0, 0, 0);
  endtask

  // From RTI: load an 8-bit instruction; ends in RTI.
  task automatic ir_scan(input logic [7:0] op);
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int k = 0; k < 8; k++) step(k == 7, op[k], 0);
    step(1, 0, 0); step(0, 0, 0);
  endtask

  function automatic logic [31:0] default_scan(input logic [31:0] din);
`ifdef SF2_UJTAG_TAP_IDCODE_EN
    return ID_VAL;
`else
    return {din[30:0], 1'b0};
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] pat;

    // ---- Vector table (starts in TLR, IR at its reset value) ----
    //  tms tdi utdo  en tdo urstb uireg  cap sh upd
    add(1, 0, 0,   0, 0, 0, 8'h00, 0, 0, 0);   // TLR
    add(0, 0, 0,   0, 0, 1, 8'h00, 0, 0, 0);   // RTI
    add(1, 0, 0,   0, 0, 1, 8'h00, 0, 0, 0);   // Select-DR
    add(1, 0, 0,   0, 0, 1, 8'h00, 0, 0, 0);   // Select-IR
    add(0, 0, 0,   0, 0, 1, 8'h00, 0, 0, 0);   // Capture-IR
    add(0, 0, 0,   1, 1, 1, 8'h00, 0, 0, 0);   // Shift-IR, LSB of 01 capture
    add(0, 0, 0,   1, 0, 1, 8'h00, 0, 0, 0);   // shift b0 of 8'h12
    add(0, 1, 0,   1, 0, 1, 8'h00, 0, 0, 0);   // b1
    add(0, 0, 0,   1, 0, 1, 8'h00, 0, 0, 0);   // b2
    add(0, 0, 0,   1, 0, 1, 8'h00, 0, 0, 0);   // b3
    add(0, 1, 0,   1, 0, 1, 8'h00, 0, 0, 0);   // b4
    add(0, 0, 0,   1, 0, 1, 8'h00, 0, 0, 0);   // b5
    add(0, 0, 0,   1, 0, 1, 8'h00, 0, 0, 0);   // b6
    add(1, 0, 0,   0, 0, 1, 8'h00, 0, 0, 0);   // b7 -> Exit1-IR
    add(1, 0, 0,   0, 0, 1, 8'h00, 0, 0, 0);   // Update-IR
    add(1, 0, 0,   0, 0, 1, 8'h12, 0, 0, 0);   // Select-DR, IR = 12
    add(0, 0, 0,   0, 0, 1, 8'h12, 1, 0, 0);   // Capture-DR (user)
    add(0, 0, 1,   1, 1, 1, 8'h12, 0, 1, 0);   // Shift-DR, TDO = UTDO
    add(0, 1, 0,   1, 0, 1, 8'h12, 0, 1, 0);
    add(0, 0, 1,   1, 1, 1, 8'h12, 0, 1, 0);
    add(1, 0, 0,   0, 0, 1, 8'h12, 0, 0, 0);   // Exit1-DR
    add(1, 0, 0,   0, 0, 1, 8'h12, 0, 0, 1);   // Update-DR (user)
    add(0, 0, 0,   0, 0, 1, 8'h12, 0, 0, 0);   // RTI
    add(1, 0, 0,   0, 0, 1, 8'h12, 0, 0, 0);   // Select-DR
    add(1, 0, 0,   0, 0, 1, 8'h12, 0, 0, 0);   // Select-IR
    add(0, 0, 0,   0, 0, 1, 8'h12, 0, 0, 0);   // Capture-IR
    add(0, 0, 0,   1, 1, 1, 8'h12, 0, 0, 0);   // Shift-IR
    for (int k = 0; k < 7; k++)
      add(0, 1, 0, 1, 0, 1, 8'h12, 0, 0, 0);   // shift in ones
    add(1, 1, 0,   0, 0, 1, 8'h12, 0, 0, 0);   // Exit1-IR
    add(1, 0, 0,   0, 0, 1, 8'h12, 0, 0, 0);   // Update-IR
    add(0, 0, 0,   0, 0, 1, 8'h00, 0, 0, 0);   // RTI, IR = FF (bypass)
    add(1, 0, 0,   0, 0, 1, 8'h00, 0, 0, 0);   // Select-DR
    add(0, 0, 0,   0, 0, 1, 8'h00, 0, 0, 0);   // Capture-DR, no strobe
    add(0, 0, 0,   1, 0, 1, 8'h00, 0, 0, 0);   // Shift-DR, bypass = 0
    add(0, 1, 0,   1, 1, 1, 8'h00, 0, 0, 0);   // TDI 1,0,1,1 -> TDO delayed
    add(0, 0, 0,   1, 0, 1, 8'h00, 0, 0, 0);
    add(0, 1, 0,   1, 1, 1, 8'h00, 0, 0, 0);
    add(1, 1, 0,   0, 0, 1, 8'h00, 0, 0, 0);   // Exit1-DR
    add(1, 0, 0,   0, 0, 1, 8'h00, 0, 0, 0);   // Update-DR, no strobe
    add(0, 0, 0,   0, 0, 1, 8'h00, 0, 0, 0);   // RTI

    // ---- Reset state ----
    ALn = 1'b0; TMS = 1'b1; TDI = 1'b0; UTDO = 1'b0;
    #12;
    check("rst.tdo",    TDO,    0);
    check("rst.tdo_en", TDO_EN, 0);
    check("rst.urstb",  URSTB,  0);
    check("rst.uireg",  UIREG,  0);
    check("rst.strobe", {UDRCAP, UDRSH, UDRUPD}, 0);
    ALn = 1'b1;
    $display("reset released");

    // ---- First DR scan after reset: IDCODE or bypass ----
    step(0, 0, 0);
    pat = 32'hA5C31E96;
    dr_scan32(pat, got);
    check("scan_after_reset", got, default_scan(pat));
    $display("first DR scan: tdo word %h", got);

    // ---- Five TMS=1 edges from Shift-DR reach TLR ----
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    check("shdr.tdo_en", TDO_EN, 1);
    for (int k = 0; k < 5; k++) step(1, 0, 0);
    check("tms5.urstb",  URSTB,  0);
    check("tms5.tdo_en", TDO_EN, 0);
    check("tms5.tdo",    TDO,    0);
    check("tms5.uireg",  UIREG,  0);
    $display("five TMS=1 edges -> TLR");

    // ---- Table-driven vectors ----
    foreach (vecs[i]) begin
      step(vecs[i].tms, vecs[i].tdi, vecs[i].utdo);
      check($sformatf("v%0d.tdo_en", i), TDO_EN, vecs[i].en);
      check($sformatf("v%0d.tdo", i),    TDO,    vecs[i].tdo);
      check($sformatf("v%0d.urstb", i),  URSTB,  vecs[i].urstb);
      check($sformatf("v%0d.uireg", i),  UIREG,  vecs[i].uireg);
      check($sformatf("v%0d.cap", i),    UDRCAP, vecs[i].cap);
      check($sformatf("v%0d.sh", i),     UDRSH,  vecs[i].sh);
      check($sformatf("v%0d.upd", i),    UDRUPD, vecs[i].upd);
      check($sformatf("v%0d.utdi", i),   UTDI,   vecs[i].tdi);
      $display("vec %0d: tms=%b tdi=%b utdo=%b -> tdo_en=%b tdo=%b urstb=%b uireg=%h cap/sh/upd=%b%b%b",
               i, vecs[i].tms, vecs[i].tdi, vecs[i].utdo, TDO_EN, TDO, URSTB, UIREG,
               UDRCAP, UDRSH, UDRUPD);
    end

    // ---- Reset pulse during the 10th Shift-DR clock of a user scan ----
    ir_scan(8'h12);
    check("mid.uireg", UIREG, 8'h12);
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 1);
    for (int k = 0; k < 9; k++) step(0, k[0], 1);
    check("mid.udrsh", UDRSH, 1);
    check("mid.tdo",   TDO,   1);
    ALn = 1'b0;
    #1;
    check("mid_rst.tdo",    TDO,    0);
    check("mid_rst.tdo_en", TDO_EN, 0);
    check("mid_rst.urstb",  URSTB,  0);
    check("mid_rst.uireg",  UIREG,  0);
    check("mid_rst.strobe", {UDRCAP, UDRSH, UDRUPD}, 0);
    #1;
    ALn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      check($sformatf("post_rst%0d.udrupd", k), UDRUPD, 0);
      check($sformatf("post_rst%0d.urstb", k),  URSTB,  0);
    end
    step(0, 0, 0);
    pat = 32'h3C96_0F5A;
    dr_scan32(pat, got);
    check("scan_after_mid_rst", got, default_scan(pat));
    $display("DR scan after mid-shift reset: tdo word %h", got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
